pc_source_unit: RTL and testbench

Parametrised program-counter unit for the multicycle datapath. It owns the PC and EPC registers and selects the next PC from five datapath sources under unconditional or branch-conditional write control. It also runs the exception-entry sequence: capture EPC, read the handler byte from the exception vector address, and load the PC with it. Control sits above it; the memory read port is shared through `exc_rd`/`exc_addr`.

---
 rtl/pc_source_unit_if.sv | 40 ++++
 rtl/pc_source_unit.sv | 123 ++++++++++++
 tb/tb_pc_source_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_source_unit_if.sv
// pc_source_unit_if
//   Bundles the control and datapath signals around the program-counter unit.
//   Clock and reset are plain ports on the unit and are not part of this bundle.
//   master : control/datapath side. It drives the write controls, the candidate
//            targets, the exception requests and the vector byte.
//   slave  : pc_source_unit. It drives pc, epc, exc_rd, exc_addr, exc_cause and busy.
interface pc_source_unit_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        pc_source;
    logic              pc_write;
    logic              pc_write_cond;
    logic              zero;
    logic              branch_ne;
    logic [DATA_W-1:0] jump_address;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mem_data;
    logic [2:0]        exc_req;
    logic [DATA_W-1:0] exc_pc;
    logic [7:0]        mem_byte;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] epc;
    logic              exc_rd;
    logic [DATA_W-1:0] exc_addr;
    logic [1:0]        exc_cause;
    logic              busy;

    modport master (
        output pc_source, pc_write, pc_write_cond, zero, branch_ne,
               jump_address, result, alu_out, mem_data, exc_req, exc_pc, mem_byte,
        input  pc, epc, exc_rd, exc_addr, exc_cause, busy
    );

    modport slave (
        input  pc_source, pc_write, pc_write_cond, zero, branch_ne,
               jump_address, result, alu_out, mem_data, exc_req, exc_pc, mem_byte,
        output pc, epc, exc_rd, exc_addr, exc_cause, busy
    );
endinterface

// File: rtl/pc_source_unit.sv
// pc_source_unit
//   Owns the PC and EPC registers. It selects the next PC from jump_address,
//   result, alu_out, mem_data or EPC. A write happens on an unconditional write,
//   or on a branch write whose condition holds. The unit also runs the
//   exception-entry sequence: it captures EPC, reads the handler byte at the
//   vector address, and loads the PC with that byte.
//   Ports: clk (rising edge), reset (async, active-high), bus (slave modport of
//   pc_source_unit_if). All outputs are registered.
//   Optional feature: when PCSRC_MISALIGN_TRAP_EN is defined, a write to a
//   target that is not word aligned traps with cause 3 instead of loading.
//
// state  | meaning
// IDLE   | normal PC writes, exception requests accepted
// VEC_RD | vector read in progress, waiting out the memory latency
// VEC_LD | handler byte valid, PC loaded, return to IDLE
module pc_source_unit #(
    parameter int DATA_W       = 32,
    parameter int RESET_PC     = 0,
    parameter int MEM_LAT      = 1,
    parameter int VEC_OPCODE   = 253,
    parameter int VEC_OVF      = 254,
    parameter int VEC_DIV0     = 255,
    parameter int VEC_MISALIGN = 252
) (
    input  logic               clk,
    input  logic               reset,
    pc_source_unit_if.slave    bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, VEC_RD, VEC_LD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pc_q, epc_q, exc_addr_q;
    logic [1:0]        cause_q;
    logic              exc_rd_q, busy_q;

    logic              we, src_ok, exc_any, trap;
    logic [DATA_W-1:0] target, vec_addr;
    logic [1:0]        cause_n;

    always_comb begin
        we     = bus.pc_write | (bus.pc_write_cond & (bus.zero ^ bus.branch_ne));
        src_ok = 1'b1;
        target = '0;
        case (bus.pc_source)
            3'b000:  target = bus.jump_address;
            3'b001:  target = bus.result;
            3'b010:  target = bus.alu_out;
            3'b011:  target = bus.mem_data;
            3'b100:  target = epc_q;
            default: src_ok = 1'b0;
        endcase

        exc_any = |bus.exc_req;
`ifdef PCSRC_MISALIGN_TRAP_EN
        trap = exc_any | (we & src_ok & (target[1:0] != 2'b00));
`else
        trap = exc_any;
`endif
        // Explicit requests outrank misalignment; among requests, opcode > ovf > div0.
        if (bus.exc_req[0])      cause_n = 2'd0;
        else if (bus.exc_req[1]) cause_n = 2'd1;
        else if (bus.exc_req[2]) cause_n = 2'd2;
        else                     cause_n = 2'd3;

        case (cause_n)
            2'd0:    vec_addr = DATA_W'(VEC_OPCODE);
            2'd1:    vec_addr = DATA_W'(VEC_OVF);
            2'd2:    vec_addr = DATA_W'(VEC_DIV0);
            default: vec_addr = DATA_W'(VEC_MISALIGN);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_q       <= DATA_W'(RESET_PC);
            epc_q      <= '0;
            exc_addr_q <= '0;
            cause_q    <= 2'd0;
            exc_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap) begin
                        // A misalignment trap records the PC that attempted the jump.
                        epc_q      <= exc_any ? bus.exc_pc : pc_q;
                        cause_q    <= cause_n;
                        exc_addr_q <= vec_addr;
                        cnt        <= CNT_W'(MEM_LAT);
                        exc_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= VEC_RD;
                    end else if (we && src_ok) begin
                        pc_q <= target;
                    end
                end
                VEC_RD: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= VEC_LD;
                end
                VEC_LD: begin
                    pc_q     <= DATA_W'(bus.mem_byte);
                    exc_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.epc       = epc_q;
    assign bus.exc_rd    = exc_rd_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.exc_cause = cause_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pc_source_unit.sv
module tb_pc_source_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    pc_source_unit_if #(.DATA_W(32)) bus ();

    pc_source_unit #(.DATA_W(32), .RESET_PC(0), .MEM_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pc_source = 3'b000; bus.pc_write = 0; bus.pc_write_cond = 0;
        bus.zero = 0; bus.branch_ne = 0;
        bus.jump_address = '0; bus.result = '0; bus.alu_out = '0; bus.mem_data = '0;
        bus.exc_req = 3'b000; bus.exc_pc = '0; bus.mem_byte = 8'h00;

        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_epc", bus.epc, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_exc_rd", {31'b0, bus.exc_rd}, 32'h0);
        check("rst_exc_addr", bus.exc_addr, 32'h0);
        check("rst_cause", {30'b0, bus.exc_cause}, 32'h0);

        // unconditional write from alu_out
        bus.pc_write = 1; bus.pc_source = 3'b010; bus.alu_out = 32'h40;
        tick();
        check("uncond_alu", bus.pc, 32'h40);

        // reserved source holds pc
        bus.pc_source = 3'b101; bus.alu_out = 32'h44;
        tick();
        check("reserved_src", bus.pc, 32'h40);

        // branch taken: zero=1, beq
        bus.pc_write = 0; bus.pc_write_cond = 1; bus.zero = 1; bus.branch_ne = 0;
        bus.pc_source = 3'b001; bus.result = 32'h80;
        tick();
        check("beq_taken", bus.pc, 32'h80);

        // bne with zero=1 not taken
        bus.branch_ne = 1; bus.result = 32'h88;
        tick();
        check("bne_not_taken", bus.pc, 32'h80);

        // bne with zero=0 taken
        bus.zero = 0; bus.result = 32'h84;
        tick();
        check("bne_taken", bus.pc, 32'h84);

        // jump to misaligned target
        bus.pc_write_cond = 0; bus.branch_ne = 0;
        bus.pc_write = 1; bus.pc_source = 3'b000; bus.jump_address = 32'h42;
        bus.mem_byte = 8'h60;
        tick();
`ifdef PCSRC_MISALIGN_TRAP_EN
        check("mis_pc_hold", bus.pc, 32'h84);
        check("mis_cause", {30'b0, bus.exc_cause}, 32'd3);
        check("mis_addr", bus.exc_addr, 32'd252);
        check("mis_epc", bus.epc, 32'h84);
        tick(); tick();
        check("mis_handler", bus.pc, 32'h60);
`else
        check("jump_unaligned", bus.pc, 32'h42);
`endif

        // mem_data source
        bus.pc_source = 3'b011; bus.mem_data = 32'h100;
        tick();
        check("mem_data_src", bus.pc, 32'h100);

        // simultaneous exceptions with competing write
        bus.exc_req = 3'b111; bus.exc_pc = 32'h1C; bus.pc_source = 3'b010;
        bus.alu_out = 32'h200; bus.mem_byte = 8'h90;
        tick();  // E0
        check("e0_epc", bus.epc, 32'h1C);
        check("e0_cause", {30'b0, bus.exc_cause}, 32'd0);
        check("e0_addr", bus.exc_addr, 32'd253);
        check("e0_pc_hold", bus.pc, 32'h100);
        check("e0_busy", {31'b0, bus.busy}, 32'h1);
        check("e0_exc_rd", {31'b0, bus.exc_rd}, 32'h1);
        bus.exc_pc = 32'h55;
        tick();  // E1
        check("e1_busy", {31'b0, bus.busy}, 32'h1);
        check("e1_exc_rd", {31'b0, bus.exc_rd}, 32'h1);
        check("e1_pc_hold", bus.pc, 32'h100);
        check("e1_epc_held", bus.epc, 32'h1C);
        tick();  // E2
        check("e2_handler", bus.pc, 32'h90);
        check("e2_busy", {31'b0, bus.busy}, 32'h0);
        check("e2_exc_rd", {31'b0, bus.exc_rd}, 32'h0);
        check("e2_cause_held", {30'b0, bus.exc_cause}, 32'd0);
        bus.exc_req = 3'b000;

        // return via EPC
        bus.pc_source = 3'b100; bus.pc_write = 1;
        tick();
        check("epc_return", bus.pc, 32'h1C);

        // ovf outranks div0
        bus.pc_write = 0; bus.exc_req = 3'b110; bus.exc_pc = 32'h30; bus.mem_byte = 8'hA0;
        tick();
        check("ovf_cause", {30'b0, bus.exc_cause}, 32'd1);
        check("ovf_addr", bus.exc_addr, 32'd254);
        check("ovf_epc", bus.epc, 32'h30);
        bus.exc_req = 3'b000;
        tick(); tick();
        check("ovf_handler", bus.pc, 32'hA0);

        // div0 alone, then reset during VEC_RD
        bus.exc_req = 3'b100; bus.exc_pc = 32'h34;
        tick();
        check("div0_cause", {30'b0, bus.exc_cause}, 32'd2);
        check("div0_addr", bus.exc_addr, 32'd255);
        bus.exc_req = 3'b000;
        #2 reset = 1'b1;
        #1;
        check("midrst_pc", bus.pc, 32'h0);
        check("midrst_epc", bus.epc, 32'h0);
        check("midrst_busy", {31'b0, bus.busy}, 32'h0);
        check("midrst_exc_rd", {31'b0, bus.exc_rd}, 32'h0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("post_rst_idle", {31'b0, bus.busy}, 32'h0);
        check("post_rst_pc", bus.pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
